mod_inverse: RTL and testbench
==============================

# mod_inverse

Sequential modular inverter: computes a^-1 mod Q by Fermat exponentiation, a^(Q-2) mod Q, using left-to-right square-and-multiply around one mod_mult instance. It is the division counterpart of the modular multiplier. The INTT scaling path uses it to derive n^-1 and per-stage twiddle inverses at configuration time. Valid/ready handshake on both sides; one operation in flight.

## Interface
- WIDTH, 32, coefficient bit width; passed to mod_mult
- Q, 3329, prime modulus; exponent E = Q-2 is an elaboration-time constant
- REDUCTION_TYPE, 0, passed to mod_mult; only 0 (simple) and 1 (Barrett) are legal; 2 raises $error at elaboration
- EXP_BITS, $clog2(Q), width of E; MSB of E must be 1 (elaboration check)

- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand a presented
- in_ready  output  1  block idle, accepts operand
- a  input  WIDTH  operand, must be < Q
- out_valid  output  1  result presented
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  a^-1 mod Q, registered
- err  output  1  registered with result; 1 = operand had no inverse (macro-dependent)

## Operation
- States: IDLE, SQUARE, MULT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: base<=a, acc<=a (consumes E's MSB), bit_idx<=EXP_BITS-2, go SQUARE.
- SQUARE: acc<=mod_mult(acc,acc). If E[bit_idx]=1 go MULT; else if bit_idx==0 go DONE, else bit_idx-- and stay SQUARE.
- MULT: acc<=mod_mult(acc,base). If bit_idx==0 go DONE, else bit_idx-- and go SQUARE.
- On the DONE transition: result<=final acc, out_valid<=1.
- DONE: hold result, err and out_valid stable until out_ready. On out_valid&&out_ready: out_valid<=0, go IDLE.
- One shared mod_mult instance; operand mux selects (acc,acc) or (acc,base) by state.
- Arithmetic: acc and base are WIDTH bits. The product is 2*WIDTH bits inside mod_mult. Every acc written after the first step is < Q.
- a >= Q: result is undefined and err is not raised; callers reduce first.
- Reset mid-operation: state goes to IDLE, outputs go to reset values, the in-flight operand is discarded, and nothing is output.
- in_valid while busy: ignored (in_ready=0); the operand must be held by the producer.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, result=0, err=0.
- Latency: L = (EXP_BITS-1) + (popcount(E)-1) cycles, from the accepting edge to the edge that sets out_valid.
- Q=3329: E=3327=0b110011111111, so L=11+9=20. Accept at edge T gives out_valid high after edge T+20.
- Handshake turnaround: in_ready rises one cycle after the out_valid&&out_ready edge. There is no same-cycle accept of the next operand.
- Throughput: one inverse per L+2 cycles with out_ready held high.
- Critical path: the mod_mult combinational path, register to register; no internal pipelining.

## Configuration
- MOD_INVERSE_ZERO_CHECK_EN defined:
  - a==0 at accept skips the exponentiation and goes directly to DONE with result=0 and err=1.
  - out_valid is high after edge T+1.
- MOD_INVERSE_ZERO_CHECK_EN undefined:
  - No zero check is compiled; a==0 runs the full L-cycle sequence and yields result=0 naturally.
  - err is tied to 0.

## Test plan
- Reset, then a=2 with out_ready=1 -> out_valid after exactly 20 cycles, result=1665, err=0; in_ready returns 1 one cycle after the handshake.
- Back-to-back operands 1, 3328, 17, 256 -> results 1, 3328, 1175, 3316 in order; in_ready low while busy.
- Backpressure: a=256, out_ready=0 for 10 cycles after out_valid -> result=3316 and out_valid stay stable; one handshake; then IDLE.
- a=0 -> with MOD_INVERSE_ZERO_CHECK_EN: result=0, err=1 after 1 cycle; without it: result=0, err=0 after 20 cycles.
- Assert rst_n low at cycle 10 of an a=17 operation -> out_valid=0, result=0, in_ready=1 immediately; next a=2 returns 1665 with no stale output.
- REDUCTION_TYPE=1 sweep a=1..3328 -> (a*result) mod 3329 == 1 for every a; matches REDUCTION_TYPE=0 bit-exactly.

Source files
------------

// File: rtl/mod_inverse.sv
// Sequential modular inverter: a^(Q-2) mod Q by left-to-right square-and-multiply around one mod_mult.
// Optional build macro MOD_INVERSE_ZERO_CHECK_EN: a==0 short-circuits to result=0, err=1.

module mod_mult #(
  parameter int WIDTH          = 32,
  parameter int Q              = 3329,
  parameter int REDUCTION_TYPE = 0
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z
);
  localparam int PW = 2 * WIDTH;
  localparam logic [PW:0] Q_EXT     = (PW + 1)'(Q);
  localparam logic [PW:0] BARRETT_M = {1'b1, {PW{1'b0}}} / Q_EXT;

  logic [PW-1:0] prod;

  function automatic logic [WIDTH-1:0] reduce_simple(input logic [PW-1:0] p);
    logic [PW:0] r;
    r = {1'b0, p} % Q_EXT;
    return WIDTH'(r);
  endfunction

  // Quotient estimate undershoots by at most 2 for any p < 2^PW, so two corrections suffice.
  function automatic logic [WIDTH-1:0] reduce_barrett(input logic [PW-1:0] p);
    logic [2*PW:0] t;
    logic [PW:0]   q_est;
    logic [PW:0]   r;
    t     = {{(PW + 1){1'b0}}, p} * {{PW{1'b0}}, BARRETT_M};
    q_est = (PW + 1)'(t >> PW);
    r     = {1'b0, p} - q_est * Q_EXT;
    if (r >= Q_EXT) r = r - Q_EXT;
    if (r >= Q_EXT) r = r - Q_EXT;
    return WIDTH'(r);
  endfunction

  assign prod = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};

  generate
    if (REDUCTION_TYPE == 1) begin : g_barrett
      assign z = reduce_barrett(prod);
    end else begin : g_simple
      assign z = reduce_simple(prod);
    end
  endgenerate
endmodule

module mod_inverse #(
  parameter int WIDTH          = 32,
  parameter int Q              = 3329,
  parameter int REDUCTION_TYPE = 0,
  parameter int EXP_BITS       = $clog2(Q)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);
  localparam logic [EXP_BITS-1:0] E = EXP_BITS'(Q - 2);
  localparam int IDX_W = (EXP_BITS > 2) ? $clog2(EXP_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_START = IDX_W'(EXP_BITS - 2);

  generate
    if (REDUCTION_TYPE != 0 && REDUCTION_TYPE != 1) begin : g_bad_reduction
      $error("mod_inverse: REDUCTION_TYPE must be 0 or 1");
    end
    if (E[EXP_BITS-1] != 1'b1) begin : g_bad_exp
      $error("mod_inverse: MSB of Q-2 must be set within EXP_BITS");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SQUARE, MULT, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] bit_idx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] mm_y;
  logic [WIDTH-1:0] mm_z;
  logic             accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && (state == IDLE);
  assign mm_y     = (state == MULT) ? base : acc;

  mod_mult #(
    .WIDTH         (WIDTH),
    .Q             (Q),
    .REDUCTION_TYPE(REDUCTION_TYPE)
  ) u_mod_mult (
    .x(acc),
    .y(mm_y),
    .z(mm_z)
  );

`ifdef MOD_INVERSE_ZERO_CHECK_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Loading acc with a consumes the exponent MSB, so the walk starts one bit below it.
  always_ff @(posedge clk) begin
    if (accept) begin
      base <= a;
      acc  <= a;
    end else if (state == SQUARE || state == MULT) begin
      acc <= mm_z;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_idx   <= '0;
      out_valid <= 1'b0;
      result    <= '0;
`ifdef MOD_INVERSE_ZERO_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
`ifdef MOD_INVERSE_ZERO_CHECK_EN
            if (a == '0) begin
              state     <= DONE;
              result    <= '0;
              err_q     <= 1'b1;
              out_valid <= 1'b1;
            end else begin
              state   <= SQUARE;
              bit_idx <= IDX_START;
            end
`else
            state   <= SQUARE;
            bit_idx <= IDX_START;
`endif
          end
        end
        SQUARE: begin
          if (E[bit_idx]) begin
            state <= MULT;
          end else if (bit_idx == '0) begin
            state     <= DONE;
            result    <= mm_z;
            out_valid <= 1'b1;
`ifdef MOD_INVERSE_ZERO_CHECK_EN
            err_q     <= 1'b0;
`endif
          end else begin
            bit_idx <= bit_idx - 1'b1;
          end
        end
        MULT: begin
          if (bit_idx == '0) begin
            state     <= DONE;
            result    <= mm_z;
            out_valid <= 1'b1;
`ifdef MOD_INVERSE_ZERO_CHECK_EN
            err_q     <= 1'b0;
`endif
          end else begin
            state   <= SQUARE;
            bit_idx <= bit_idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_inverse.sv
// Scoreboard bench for mod_inverse: Barrett and simple-reduction instances run in lockstep against an extended-Euclid model.
module tb_mod_inverse;
  localparam int WIDTH = 32;
  localparam int Q     = 3329;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] a = '0;
  logic             in_ready1, out_valid1, err1;
  logic             in_ready0, out_valid0, err0;
  logic [WIDTH-1:0] result1, result0;

  always #5 clk = ~clk;

  mod_inverse #(.WIDTH(WIDTH), .Q(Q), .REDUCTION_TYPE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .a(a),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1), .err(err1)
  );

  mod_inverse #(.WIDTH(WIDTH), .Q(Q), .REDUCTION_TYPE(0)) dut_simple (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .a(a),
    .out_valid(out_valid0), .out_ready(out_ready), .result(result0), .err(err0)
  );

  typedef struct {
    int unsigned a;
    int unsigned res;
    bit          err;
    longint      lat;
    longint      acc_cyc;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fail = 0;
  longint cyc = 0;
  bit     rand_rdy = 1'b0;
  int     lat_full;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic report_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Inverse by the extended Euclidean algorithm; 0 has no inverse and maps to 0.
  function automatic int unsigned ref_inv(input int unsigned x);
    longint t = 0, nt = 1, r = Q, nr = x % Q, qq, tmp;
    if (nr == 0) return 0;
    while (nr != 0) begin
      qq = r / nr;
      tmp = t - qq * nt; t = nt; nt = tmp;
      tmp = r - qq * nr; r = nr; nr = tmp;
    end
    if (t < 0) t += Q;
    return int'(t);
  endfunction

  function automatic int exp_latency();
    int e = Q - 2, nbits = 0, ones = 0;
    while (e != 0) begin
      nbits++;
      ones += e & 1;
      e = e >> 1;
    end
    return (nbits - 1) + (ones - 1);
  endfunction

  task automatic issue(input int unsigned v);
    int   guard = 0;
    exp_t e;
    a = v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready1) begin
      report_fail("issue_timeout");
    end else begin
      e.a = v;
      e.res = ref_inv(v);
`ifdef MOD_INVERSE_ZERO_CHECK_EN
      e.err = (v == 0);
      e.lat = (v == 0) ? 1 : lat_full;
`else
      e.err = 1'b0;
      e.lat = lat_full;
`endif
      e.acc_cyc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while ((sb.size() != 0 || out_valid1) && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    if (sb.size() != 0 || out_valid1) report_fail({name, "_drain_timeout"});
  endtask

  initial begin : rdy_driver
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : monitor
    bit               ov_prev = 1'b0;
    bit               hs_prev = 1'b0;
    logic [WIDTH-1:0] held = '0;
    exp_t             e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ov_prev = 1'b0;
        hs_prev = 1'b0;
        continue;
      end
      if (hs_prev) begin
        check("turnaround_in_ready", in_ready1, 1);
        check("turnaround_out_valid", out_valid1, 0);
      end
      hs_prev = 1'b0;
      check("lockstep_out_valid", out_valid0, out_valid1);
      check("lockstep_in_ready", in_ready0, in_ready1);
      if (out_valid1) begin
        check("busy_in_ready", in_ready1, 0);
        if (ov_prev) begin
          check("hold_result", result1, held);
        end else if (sb.size() == 0) begin
          report_fail("unexpected_output");
        end else begin
          check("latency", cyc - sb[0].acc_cyc, sb[0].lat);
        end
        held = result1;
        if (out_ready) begin
          hs_prev = 1'b1;
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("result_barrett", result1, e.res);
            check("result_simple", result0, e.res);
            check("err_barrett", err1, e.err);
            check("err_simple", err0, e.err);
            if (e.a != 0) check("inverse_identity", (longint'(e.a) * result1) % Q, 1);
          end
        end
      end
      ov_prev = out_valid1 && !out_ready;
    end
  end

  initial begin : stimulus
    int guard;
    lat_full = exp_latency();

    // Reset values
    #12;
    check("reset_in_ready", in_ready1, 1);
    check("reset_out_valid", out_valid1, 0);
    check("reset_result", result1, 0);
    check("reset_err", err1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single operand, then back-to-back directed operands
    issue(2);
    drain("single");
    issue(1);
    @(negedge clk);
    check("busy_after_accept", in_ready1, 0);
    @(posedge clk);
    #1;
    issue(3328);
    issue(17);
    issue(256);
    drain("b2b");

    // Backpressure: hold out_ready low for 10 cycles after out_valid
    out_ready = 1'b0;
    issue(256);
    guard = 0;
    while (!out_valid1 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!out_valid1) report_fail("backpressure_wait_timeout");
    repeat (10) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("backpressure");

    // Zero operand
    issue(0);
    drain("zero");

    // Reset in the middle of an operation
    issue(17);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid1, 0);
    check("midreset_result", result1, 0);
    check("midreset_in_ready", in_ready1, 1);
    check("midreset_err", err1, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(2);
    drain("after_reset");

    // Strided sweep across the operand range, then random operands with random backpressure
    for (int v = 1; v < Q; v += 7) issue(v);
    issue(Q - 1);
    drain("sweep");
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) issue($urandom_range(0, Q - 1));
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
